// File: rtl/tx_buffer_pkg.sv
// Shared helpers for the transmitter input buffer: lane arithmetic and parameter legality.
package tx_buffer_pkg;

  function automatic int unsigned lanes(input int unsigned in_w, input int unsigned out_w);
    return out_w / in_w;
  endfunction

  function automatic bit params_ok(input int unsigned in_w, input int unsigned out_w,
                                   input int unsigned depth);
    return (in_w > 0) && (out_w % in_w == 0) && (out_w / in_w >= 2) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// First-word-fall-through word FIFO; head word is visible on o_rd_data whenever o_valid is high.
module tx_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  always_comb begin
    o_full    = (r_count == CW'(DEPTH));
    o_valid   = (r_count != '0);
    w_wr      = i_wr && !o_full;
    w_rd      = i_rd && o_valid;
    o_rd_data = o_valid ? r_mem[r_rd_ptr] : '0;
    o_count   = r_count;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/tx_input_packer.sv
// Packs IN_WIDTH-bit symbols MSB-lane-first into OUT_WIDTH-bit words and queues them in a FWFT FIFO.
module tx_input_packer
  import tx_buffer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned LANES    = lanes(IN_WIDTH, OUT_WIDTH),
  localparam int unsigned LW       = $clog2(LANES),
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [IN_WIDTH-1:0]  i_shift_in,
  input  logic                 i_push,
  input  logic                 i_flush,
  output logic                 o_in_ready,
  input  logic                 i_pop,
  output logic [OUT_WIDTH-1:0] o_shift_out,
  output logic                 o_out_valid,
  output logic                 o_full,
  output logic [CW-1:0]        o_count,
  output logic [LW-1:0]        o_lane_cnt,
  output logic                 o_overflow
);

  if (!params_ok(IN_WIDTH, OUT_WIDTH, DEPTH)) begin : g_param_check
    $error("tx_input_packer: OUT_WIDTH must be a multiple of IN_WIDTH and DEPTH a power of two");
  end

  localparam logic [LW:0] LaneFull = LANES[LW:0];

  logic [OUT_WIDTH-1:0] r_asm;
  logic [LW-1:0]        r_lane;
  logic                 r_overflow;

  logic                 w_full;
  logic                 w_in_ready;
  logic                 w_push_acc;
  logic                 w_flush_acc;
  logic                 w_commit;
  logic [LW:0]          w_fill;
  logic [OUT_WIDTH-1:0] w_asm_next;
  logic [OUT_WIDTH-1:0] w_commit_word;

  always_comb begin
    w_in_ready  = !w_full;
    w_push_acc  = i_push && w_in_ready;
    w_flush_acc = i_flush && w_in_ready;
    w_asm_next  = r_asm;
    if (w_push_acc) w_asm_next = {r_asm[OUT_WIDTH-IN_WIDTH-1:0], i_shift_in};
    w_fill   = {1'b0, r_lane} + {{LW{1'b0}}, w_push_acc};
    w_commit = (w_fill == LaneFull) || (w_flush_acc && (w_fill != '0));
    // Left-align a partial word so the first symbol lands in the MSB lane.
    w_commit_word = w_asm_next << (IN_WIDTH * (LANES - 32'(w_fill)));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_asm      <= '0;
      r_lane     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if ((i_push || i_flush) && !w_in_ready) r_overflow <= 1'b1;
      if (w_commit) begin
        r_asm  <= '0;
        r_lane <= '0;
      end else if (w_push_acc) begin
        r_asm  <= w_asm_next;
        r_lane <= r_lane + 1'b1;
      end
    end
  end

  tx_word_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_wr      (w_commit),
    .i_wr_data (w_commit_word),
    .i_rd      (i_pop),
    .o_rd_data (o_shift_out),
    .o_valid   (o_out_valid),
    .o_full    (w_full),
    .o_count   (o_count)
  );

  assign o_full     = w_full;
  assign o_in_ready = w_in_ready;
  assign o_lane_cnt = r_lane;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_tx_input_packer.sv
// Scoreboard bench: a symbol-list reference model queues expected words; a negedge monitor checks.
module tb_tx_input_packer;

  localparam int DP = 4;
  localparam int LN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, push = 1'b0, flush = 1'b0, pop = 1'b0;
  logic [7:0]  sym = '0;
  logic        in_ready, out_valid, full, overflow;
  logic [31:0] shift_out;
  logic [2:0]  count;
  logic [1:0]  lane_cnt;

  logic        b_rst = 1'b1, b_push = 1'b0, b_flush = 1'b0, b_pop = 1'b0;
  logic [3:0]  b_sym = '0;
  logic        b_in_ready, b_out_valid, b_full, b_overflow;
  logic [15:0] b_shift_out;
  logic [1:0]  b_count;
  logic [1:0]  b_lane_cnt;

  tx_input_packer u_dut (
    .i_clock(clk), .i_reset(rst), .i_shift_in(sym), .i_push(push), .i_flush(flush),
    .o_in_ready(in_ready), .i_pop(pop), .o_shift_out(shift_out), .o_out_valid(out_valid),
    .o_full(full), .o_count(count), .o_lane_cnt(lane_cnt), .o_overflow(overflow)
  );

  tx_input_packer #(.IN_WIDTH(4), .OUT_WIDTH(16), .DEPTH(2)) u_dut_b (
    .i_clock(clk), .i_reset(b_rst), .i_shift_in(b_sym), .i_push(b_push), .i_flush(b_flush),
    .o_in_ready(b_in_ready), .i_pop(b_pop), .o_shift_out(b_shift_out),
    .o_out_valid(b_out_valid), .o_full(b_full), .o_count(b_count), .o_lane_cnt(b_lane_cnt),
    .o_overflow(b_overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending symbols as a list, words as a queue, a count and a sticky flag.
  logic [7:0]  partial[$];
  logic [31:0] exp_q[$];
  int          m_count = 0;
  bit          m_ovf   = 1'b0;
  bit          mon_en  = 1'b0;
  bit          l_push = 0, l_flush = 0, l_pop = 0, l_rst = 1;
  logic [7:0]  l_sym = '0;

  function automatic void model_step();
    int          popped;
    int          commit;
    logic [31:0] w;
    if (l_rst) begin
      partial.delete();
      exp_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      return;
    end
    popped = (l_pop && m_count > 0) ? 1 : 0;
    commit = 0;
    if ((l_push || l_flush) && m_count >= DP) begin
      m_ovf = 1'b1;
    end else begin
      if (l_push) partial.push_back(l_sym);
      if (partial.size() == LN || (l_flush && partial.size() > 0)) begin
        w = '0;
        for (int i = 0; i < LN; i++) w = {w[23:0], (i < partial.size()) ? partial[i] : 8'h00};
        exp_q.push_back(w);
        partial.delete();
        commit = 1;
      end
    end
    m_count = m_count - popped + commit;
  endfunction

  task automatic step(input bit p, input bit f, input bit po, input logic [7:0] s, input bit r);
    @(posedge clk);
    #1;
    model_step();
    mon_en = 1'b1;
    push = p; flush = f; pop = po; sym = s; rst = r;
    l_push = p; l_flush = f; l_pop = po; l_sym = s; l_rst = r;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic bstep(input bit p, input bit po, input logic [3:0] s);
    idle();
    b_push = p; b_pop = po; b_sym = s; b_flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 64'(count), 64'(m_count));
      check("out_valid", 64'(out_valid), 64'(m_count > 0));
      check("full", 64'(full), 64'(m_count == DP));
      check("in_ready", 64'(in_ready), 64'(m_count < DP));
      check("lane_cnt", 64'(lane_cnt), 64'(partial.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: DUT word 0x%0h, expected no word", shift_out);
        end else begin
          check("shift_out", 64'(shift_out), 64'(exp_q[0]));
          if (pop && !rst) void'(exp_q.pop_front());
        end
      end else begin
        check("shift_out_idle", 64'(shift_out), 64'h0);
      end
    end
  end

  initial begin
    step(0, 0, 0, 8'h00, 1);
    idle();
    b_rst = 1'b0;
    @(negedge clk);
    check("rst_shift_out", 64'(shift_out), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);

    // Four symbols form one word, visible the cycle after the last push.
    step(1, 0, 0, 8'h01, 0);
    step(1, 0, 0, 8'h02, 0);
    step(1, 0, 0, 8'h04, 0);
    step(1, 0, 0, 8'h08, 0);
    idle();
    @(negedge clk);
    check("word_basic", 64'(shift_out), 64'h01020408);
    check("word_basic_valid", 64'(out_valid), 64'h1);
    step(0, 0, 1, 8'h00, 0);
    idle();
    @(negedge clk);
    check("pop_empty_valid", 64'(out_valid), 64'h0);

    // Flush of a partial word, then a no-op flush.
    step(1, 0, 0, 8'hAA, 0);
    step(1, 0, 0, 8'hBB, 0);
    step(0, 1, 0, 8'h00, 0);
    idle();
    @(negedge clk);
    check("flush_word", 64'(shift_out), 64'hAABB0000);
    check("flush_lane", 64'(lane_cnt), 64'h0);
    step(0, 1, 0, 8'h00, 0);
    idle();
    @(negedge clk);
    check("flush_noop_count", 64'(count), 64'h1);
    step(0, 0, 1, 8'h00, 0);
    idle();

    // Fill to full, overflow on the 17th push, then pop from full.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i), 0);
    idle();
    @(negedge clk);
    check("fill_full", 64'(full), 64'h1);
    check("fill_not_ready", 64'(in_ready), 64'h0);
    step(1, 0, 0, 8'hEE, 0);
    idle();
    @(negedge clk);
    check("overflow_set", 64'(overflow), 64'h1);
    step(1, 0, 1, 8'hEF, 0);
    @(negedge clk);
    check("pop_full_same_cycle", 64'(in_ready), 64'h0);
    idle();
    @(negedge clk);
    check("pop_full_next_ready", 64'(in_ready), 64'h1);
    check("second_word", 64'(shift_out), 64'h04050607);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    idle();

    // Streaming with a pop every fourth cycle.
    for (int i = 0; i < 40; i++) begin
      step(1, 0, (i % 4) == 3, 8'(8'h40 + i), 0);
      @(negedge clk);
      check("stream_count_le1", 64'(count <= 1), 64'h1);
    end
    step(0, 0, 1, 8'h00, 0);
    idle();

    // Push+flush in the same cycle, then reset mid-word.
    step(1, 0, 0, 8'h11, 0);
    step(1, 0, 0, 8'h22, 0);
    step(1, 1, 0, 8'h33, 0);
    idle();
    @(negedge clk);
    check("pushflush_word", 64'(shift_out), 64'h11223300);
    step(0, 0, 1, 8'h00, 0);
    step(1, 0, 0, 8'h44, 0);
    step(1, 0, 0, 8'h55, 0);
    step(0, 0, 0, 8'h00, 1);
    idle();
    @(negedge clk);
    check("midword_rst_lane", 64'(lane_cnt), 64'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'hC0 + i), 0);
    idle();
    @(negedge clk);
    check("post_rst_word", 64'(shift_out), 64'hC0C1C2C3);
    step(0, 0, 1, 8'h00, 0);

    // Randomized traffic with shifting pop pressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      int pp;
      bit r;
      pp = (i < 1000) ? 30 : (i < 2000) ? 60 : 15;
      r  = ($urandom_range(0, 499) == 0);
      step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 8,
           !r && ($urandom_range(0, 99) < pp), 8'($urandom), r);
    end
    idle();
    idle();

    // Narrow configuration: 4-bit symbols, 16-bit words, two entries.
    bstep(1, 0, 4'h1);
    bstep(1, 0, 4'h2);
    bstep(1, 0, 4'h3);
    bstep(1, 0, 4'h4);
    bstep(0, 0, 4'h0);
    @(negedge clk);
    check("b_word", 64'(b_shift_out), 64'h1234);
    check("b_valid", 64'(b_out_valid), 64'h1);
    bstep(0, 1, 4'h0);
    bstep(0, 1, 4'h0);
    bstep(0, 0, 4'h0);
    @(negedge clk);
    check("b_pop_empty_count", 64'(b_count), 64'h0);
    check("b_pop_empty_ovf", 64'(b_overflow), 64'h0);
    check("b_pop_empty_out", 64'(b_shift_out), 64'h0);
    for (int i = 0; i < 8; i++) bstep(1, 0, 4'(i + 5));
    bstep(0, 0, 4'h0);
    @(negedge clk);
    check("b_full", 64'(b_full), 64'h1);
    check("b_full_head", 64'(b_shift_out), 64'h5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
